// File: rtl/mac_seq_ctrl.sv
// MAC job sequencer: accepts one job, clears the shift-accumulator, streams the
// activation bits MSB-first, captures nout into a result register and holds it.
//
// state     | meaning
// S_IDLE    | waiting for a job, start_ready_o high
// S_CLEAR   | one cycle of st_o to clear the accumulator
// S_ACCUM   | N cycles streaming act_bit_o with acm_en_o high
// S_CAPTURE | accumulator settled, nout_i registered into res_data_o
// S_HOLD    | result presented until res_ready_i
module mac_seq_ctrl #(
  parameter int IN_BITS_MAX = 16,
  parameter int CNT_W       = 5,
  parameter int NOUT_W      = 51
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_valid_i,
  output logic                   start_ready_o,
  input  logic [IN_BITS_MAX-1:0] act_data_i,
  input  logic [CNT_W-1:0]       in_bits_i,
  input  logic                   wwidth_in_i,
  output logic                   act_bit_o,
  output logic                   st_o,
  output logic                   acm_en_o,
  output logic                   wwidth_o,
  input  logic [NOUT_W-1:0]      nout_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [NOUT_W-1:0]      res_data_o,
  output logic                   busy_o
);

  localparam int IDX_W = (IN_BITS_MAX > 1) ? $clog2(IN_BITS_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [IN_BITS_MAX-1:0] act_q, act_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wwidth_q, wwidth_d;
  logic [NOUT_W-1:0]      res_q, res_d;
  logic                   rdy_q, rdy_d;
  logic [CNT_W-1:0]       n_eff;

  // Out-of-range counts (zero or above the word width) run a full-width job.
  always_comb begin
    n_eff = in_bits_i;
    if ((in_bits_i == '0) || (in_bits_i > CNT_W'(IN_BITS_MAX))) begin
      n_eff = CNT_W'(IN_BITS_MAX);
    end
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    idx_d    = idx_q;
    wwidth_d = wwidth_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid_i && rdy_q) begin
          act_d    = act_data_i;
          wwidth_d = wwidth_in_i;
          idx_d    = IDX_W'(n_eff - CNT_W'(1));
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_ACCUM;
      S_ACCUM: begin
        if (idx_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_CAPTURE: begin
        res_d   = nout_i;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered ready keeps start_ready_o low while reset is held.
  assign rdy_d = (state_d == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      act_q    <= '0;
      idx_q    <= '0;
      wwidth_q <= 1'b0;
      res_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      idx_q    <= idx_d;
      wwidth_q <= wwidth_d;
      res_q    <= res_d;
      rdy_q    <= rdy_d;
    end
  end

  assign start_ready_o = rdy_q;
  assign st_o          = (state_q == S_CLEAR);
  assign acm_en_o      = (state_q == S_ACCUM);
  assign act_bit_o     = (state_q == S_ACCUM) && act_q[idx_q];
  assign wwidth_o      = wwidth_q;
  assign res_valid_o   = (state_q == S_HOLD);
  assign res_data_o    = res_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural shift-accumulator/array in the loop
// and a job-timeline reference model checked every cycle.
module tb_mac_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_valid_i = 1'b0;
  logic        start_ready_o;
  logic [15:0] act_data_i = '0;
  logic [4:0]  in_bits_i = '0;
  logic        wwidth_in_i = 1'b0;
  logic        act_bit_o, st_o, acm_en_o, wwidth_o;
  logic [50:0] nout = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [50:0] res_data_o;
  logic        busy_o;
  logic [11:0] wa = '0, wb = '0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int st_cnt = 0, acm_cnt = 0;

  mac_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
    .act_data_i(act_data_i), .in_bits_i(in_bits_i), .wwidth_in_i(wwidth_in_i),
    .act_bit_o(act_bit_o), .st_o(st_o), .acm_en_o(acm_en_o), .wwidth_o(wwidth_o),
    .nout_i(nout), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Array + shift-accumulator: 24-bit mode folds WB in above WA's 12 bits.
  wire [50:0] mac_in = act_bit_o ? (wwidth_o ? (51'(wa) + (51'(wb) << 12)) : 51'(wa)) : 51'd0;

  always @(posedge clk_i) begin
    if (rst_i || st_o) nout <= '0;
    else if (acm_en_o) nout <= (nout << 1) + mac_in;
  end

  function automatic int sat_bits(input int b);
    return (b == 0 || b > 16) ? 16 : b;
  endfunction

  function automatic longint unsigned job_value(input logic [15:0] d, input int n, input bit ww,
                                                input longint unsigned a, input longint unsigned b);
    longint unsigned v = 0;
    for (int i = 0; i < n; i++) if (d[i]) v += (64'd1 << i);
    return v * (ww ? (a + b * 4096) : a);
  endfunction

  // Reference model: cycles since accept (m_t) decide every output.
  // 1 = clear, 2..N+1 = stream, N+2 = capture, N+3 onward = result held.
  bit               m_busy = 0, m_rdy = 0, m_ww = 0;
  int               m_t = 0, m_n = 16;
  logic [15:0]      m_data = '0;
  longint unsigned  m_res = 0, m_exp = 0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_busy <= 0; m_rdy <= 0; m_ww <= 0; m_res <= 0; m_t <= 0;
    end else if (!m_busy) begin
      if (m_rdy && start_valid_i) begin
        m_busy <= 1; m_rdy <= 0; m_t <= 1;
        m_n    <= sat_bits(int'(in_bits_i));
        m_data <= act_data_i;
        m_ww   <= wwidth_in_i;
        m_exp  <= job_value(act_data_i, sat_bits(int'(in_bits_i)), wwidth_in_i, wa, wb);
      end else begin
        m_rdy <= 1;
      end
    end else if (m_t >= m_n + 3) begin
      if (res_ready_i) begin m_busy <= 0; m_rdy <= 1; end
    end else begin
      if (m_t == m_n + 2) m_res <= m_exp;
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++; n_err++;
    $display("FAIL %s: timeout got no event expected event at %0t", name, $time);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      bit e_acm;
      e_acm = m_busy && (m_t >= 2) && (m_t <= m_n + 1);
      check("start_ready", 64'(start_ready_o), 64'(m_rdy));
      check("busy",        64'(busy_o),        64'(m_busy));
      check("st",          64'(st_o),          64'(m_busy && m_t == 1));
      check("acm_en",      64'(acm_en_o),      64'(e_acm));
      check("act_bit",     64'(act_bit_o),     e_acm ? 64'(m_data[m_n + 1 - m_t]) : 64'd0);
      check("wwidth",      64'(wwidth_o),      64'(m_ww));
      check("res_valid",   64'(res_valid_o),   64'(m_busy && m_t >= m_n + 3));
      check("res_data",    64'(res_data_o),    m_res);
      if (st_o) st_cnt++;
      if (acm_en_o) acm_cnt++;
    end
  end

  task automatic start_job(input logic [15:0] d, input logic [4:0] b, input bit ww,
                           input logic [11:0] a, input logic [11:0] w);
    int k = 0;
    @(negedge clk_i);
    act_data_i = d; in_bits_i = b; wwidth_in_i = ww; wa = a; wb = w;
    start_valid_i = 1'b1;
    while (!start_ready_o && k < 40) begin @(negedge clk_i); k++; end
    if (!start_ready_o) fail_timeout("accept");
    @(negedge clk_i);
    start_valid_i = 1'b0;
  endtask

  // Entered at the negedge of the first cycle after the accept edge.
  task automatic wait_result(input string name, input longint unsigned exp, input int exp_edges);
    int edges = 0;
    while (!res_valid_o && edges < 60) begin @(negedge clk_i); edges++; end
    if (!res_valid_o) fail_timeout({name, "_valid"});
    check({name, "_data"}, 64'(res_data_o), exp);
    check({name, "_model"}, m_res, exp);
    if (exp_edges > 0) check({name, "_latency"}, 64'(edges), 64'(exp_edges));
    if (res_ready_i) @(negedge clk_i);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_en = 1'b1;
    check("rst_start_ready", 64'(start_ready_o), 0);
    check("rst_res_data", 64'(res_data_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rel_start_ready", 64'(start_ready_o), 1);

    // 12-bit mode: 0b101 * 7
    st_cnt = 0; acm_cnt = 0;
    start_job(16'b101, 5'd3, 1'b0, 12'd7, 12'd999);
    wait_result("job12", 35, 5);
    check("job12_st_cycles", 64'(st_cnt), 1);
    check("job12_acm_cycles", 64'(acm_cnt), 3);

    // 24-bit mode: 0b11 * (10 + 1*4096)
    start_job(16'b11, 5'd2, 1'b1, 12'd10, 12'd1);
    wait_result("job24", 12318, 4);

    // Saturation: count 0 and count 20 both run 16 bits
    start_job(16'hFFFF, 5'd0, 1'b0, 12'd1, 12'd0);
    wait_result("sat0", 65535, 18);
    start_job(16'hFFFF, 5'd20, 1'b0, 12'd1, 12'd0);
    wait_result("sat20", 65535, 18);

    // Backpressure with a second request pending during HOLD
    res_ready_i = 1'b0;
    start_job(16'b101, 5'd3, 1'b0, 12'd3, 12'd0);
    wait_result("bp_a", 15, 5);
    act_data_i = 16'b110; in_bits_i = 5'd3; wwidth_in_i = 1'b0;
    start_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("bp_hold_data", 64'(res_data_o), 15);
      check("bp_hold_ready", 64'(start_ready_o), 0);
    end
    res_ready_i = 1'b1;
    wa = 12'd2;
    start_job(16'b110, 5'd3, 1'b0, 12'd2, 12'd0);
    wait_result("bp_b", 12, 5);

    // Reset after two of four bits have been accumulated
    start_job(16'hF, 5'd4, 1'b1, 12'd3, 12'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_busy", 64'(busy_o), 0);
    check("mid_rst_acm", 64'(acm_en_o), 0);
    check("mid_rst_wwidth", 64'(wwidth_o), 0);
    rst_i = 1'b0;
    start_job(16'b1, 5'd1, 1'b0, 12'd5, 12'd0);
    wait_result("post_rst", 5, 3);

    // Random traffic with occasional resets; the per-cycle compare does the checking
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      rst_i         = ($urandom_range(0, 249) == 0);
      start_valid_i = ($urandom_range(0, 3) != 0);
      res_ready_i   = ($urandom_range(0, 2) != 0);
      act_data_i    = 16'($urandom);
      in_bits_i     = 5'($urandom_range(0, 31));
      wwidth_in_i   = 1'($urandom_range(0, 1));
      if (!m_busy) begin
        wa = 12'($urandom);
        wb = 12'($urandom);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0; start_valid_i = 1'b0; res_ready_i = 1'b1;
    repeat (30) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Job sequencer directly upstream of `global_io` in the DCIM macro datapath. Accepts one MAC job per request (parallel activation word, bit count, weight-width mode), clears the shift-accumulator, streams activation bits MSB-first to the array while driving `st`/`acm_en`/`wwidth`, then captures the final `nout` into a result register with a valid/ready handshake. One job in flight at a time.

## Interface
- `IN_BITS_MAX`, 16: maximum activation bits per job; width of `act_data`.
- `CNT_W`, 5: width of `in_bits`; must hold `IN_BITS_MAX`.
- `NOUT_W`, 51: accumulator/result width; matches `global_io` `nout`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  job request.
- `start_ready`  out  1  job accepted when `start_valid && start_ready` at a rising edge.
- `act_data`  in  IN_BITS_MAX  activation word, sampled on accept.
- `in_bits`  in  CNT_W  bits to stream; sampled on accept.
- `wwidth_in`  in  1  0 = 12-bit weight mode, 1 = 24-bit; sampled on accept.
- `act_bit`  out  1  serial activation bit to the array.
- `st`  out  1  accumulator clear to `global_io`.
- `acm_en`  out  1  accumulate enable to `global_io`.
- `wwidth`  out  1  latched weight mode to `global_io`.
- `nout`  in  NOUT_W  accumulator value from `global_io`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  NOUT_W  captured result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are decoded from or held in registers; no combinational input-to-output path except none (`start_ready` depends on state only).
- States: IDLE, CLEAR, ACCUM, CAPTURE, HOLD.
- IDLE: `start_ready`=1, `st`=0, `acm_en`=0. On accept: latch `act_data`, `wwidth_in`→`wwidth`, effective count N → CLEAR.
- N = `in_bits`, except `in_bits`=0 or `in_bits`>IN_BITS_MAX → N = IN_BITS_MAX (saturate).
- CLEAR (1 cycle): `st`=1, `acm_en`=0; load bit index = N-1 → ACCUM.
- ACCUM (N cycles): `st`=0, `acm_en`=1, `act_bit` = latched `act_data[index]`; index decrements each edge; edge at index 0 → CAPTURE.
- CAPTURE (1 cycle): `acm_en`=0, `act_bit`=0; on edge `res_data` <= `nout` → HOLD.
- HOLD: `res_valid`=1, `res_data` stable; `start_ready`=0. On `res_ready` → IDLE, `res_valid` drops next cycle.
- `wwidth` held constant from accept through HOLD; changes only on accept.
- `start_valid` outside IDLE is ignored (not queued).
- Data bits of `act_data` above index N-1 are ignored.

## Timing
- Reset (`rst`=1 at edge): state IDLE; `st`=0, `acm_en`=0, `act_bit`=0, `wwidth`=0, `res_valid`=0, `res_data`=0, `busy`=0. `start_ready`=0 while `rst` high, 1 the cycle after release.
- Reset mid-job (any state): abort immediately, outputs to reset values; partial result discarded; next job's CLEAR guarantees clean accumulator.
- Array path assumed combinational: `act_bit` in cycle k contributes to `nout` at the edge closing cycle k.
- Latency: accept edge = E0; `st` high in cycle after E0; `acm_en` high for cycles after E1..E(N); `res_valid` high after E(N+2).
- Throughput: minimum N+4 cycles per job (CLEAR + N + CAPTURE + ≥1 HOLD + IDLE accept).
- `res_ready` high in first HOLD cycle → exactly one cycle of `res_valid`.
- Accept and result handshake can never coincide (disjoint states).

## Test plan
- Bench: `mac_seq_ctrl` + `global_io` + array model (`macout_a` = `act_bit` ? WA : 0, `macout_b` = `act_bit` ? WB : 0), `rstn` of `global_io` = ~`rst`.
- 12-bit: WA=7, WB=999, `act_data`=0b101, `in_bits`=3, `wwidth_in`=0 → `res_data`=35, `res_valid` 5 edges after accept, `st` high exactly 1 cycle, `acm_en` high exactly 3.
- 24-bit: WA=10, WB=1, `act_data`=0b11, `in_bits`=2, `wwidth_in`=1 → `res_data`=12318; `wwidth`=1 throughout job.
- Saturation: `in_bits`=0, `act_data`=0xFFFF, WA=1 → 16 ACCUM cycles, `res_data`=65535; then `in_bits`=20 → identical.
- Backpressure: hold `res_ready`=0 for 6 cycles with `start_valid`=1 → `res_data` stable, `start_ready`=0, no new `st`; `res_ready`=1 → IDLE, next job accepted, `res_data` of second job correct (no carry-over).
- Reset mid-ACCUM after 2 of 4 bits → all outputs reset values next cycle; following job `act_data`=0b1, `in_bits`=1, WA=5 → `res_data`=5.
